// File: rtl/page_chain_reader_pkg.sv
// Shared constants, FSM state encoding and jump-table field layout for the
// page chain reader.
package page_chain_reader_pkg;

    localparam int PCR_ADDR_WIDTH = 11;  // 2048 pages
    localparam int PCR_PORT_WIDTH = 4;   // 16 ports
    localparam int PCR_JT_WIDTH   = 16;  // jump-table entry width

    // Next-page pointer occupies the low bits of a jump-table entry;
    // anything above it is ignored by this block.
    localparam int JT_NEXT_LSB = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        EMIT   = 2'd2
    } state_t;

endpackage

// File: rtl/page_chain_reader.sv
// Walks a packet's linked page chain through the jump table, presents each
// page downstream and releases every consumed page back to the pool.
module page_chain_reader
    import page_chain_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = PCR_ADDR_WIDTH,
    parameter int PORT_WIDTH = PCR_PORT_WIDTH,
    parameter int JT_WIDTH   = PCR_JT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [PORT_WIDTH-1:0] req_port,
    input  logic [ADDR_WIDTH-1:0] req_head,
    input  logic [ADDR_WIDTH-1:0] req_len,
    output logic                  page_valid,
    input  logic                  page_ready,
    output logic [ADDR_WIDTH-1:0] page_addr,
    output logic                  page_last,
    output logic                  jt_rd_en,
    output logic [ADDR_WIDTH-1:0] jt_rd_addr,
    input  logic [JT_WIDTH-1:0]   jt_dout,
    output logic                  ecc_rd_en,
    output logic [ADDR_WIDTH-1:0] ecc_rd_addr,
    output logic                  rd_op,
    output logic [PORT_WIDTH-1:0] rd_port,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  len_err,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] cur;        // page currently being looked up / emitted
    logic [ADDR_WIDTH-1:0] nxt;        // next pointer captured from the jump table
    logic [ADDR_WIDTH-1:0] remaining;  // pages left including cur, never below 1
    logic [PORT_WIDTH-1:0] port;
    logic                  first_emit; // jt_dout is only valid in the first EMIT cycle

    logic [ADDR_WIDTH-1:0] jt_next;
    logic [ADDR_WIDTH-1:0] next_ptr;
    logic                  is_last;
    logic                  accept;
    logic                  consume;
    logic                  jt_unused;

    assign jt_next   = jt_dout[JT_NEXT_LSB +: ADDR_WIDTH];
    assign jt_unused = ^jt_dout[JT_WIDTH-1:ADDR_WIDTH];
    assign next_ptr  = first_emit ? jt_next : nxt;
    assign is_last   = (remaining == ONE);
    assign accept    = (state == IDLE) && req_valid;
    assign consume   = (state == EMIT) && page_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all clocked state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake/strobe outputs decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a signal unassigned, which would infer a latch.
        state_next = state;
        req_ready  = 1'b0;
        page_valid = 1'b0;
        page_addr  = '0;
        page_last  = 1'b0;
        jt_rd_en   = 1'b0;
        jt_rd_addr = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && (req_len != '0)) state_next = LOOKUP;
            end
            LOOKUP: begin
                jt_rd_en   = 1'b1;
                jt_rd_addr = cur;
                state_next = EMIT;
            end
            EMIT: begin
                page_valid = 1'b1;
                page_addr  = cur;
                page_last  = is_last;
                if (page_ready) state_next = is_last ? IDLE : LOOKUP;
            end
            default: state_next = IDLE;
        endcase
    end

    assign ecc_rd_en   = jt_rd_en;
    assign ecc_rd_addr = jt_rd_addr;
    assign busy        = (state != IDLE);

    // Chain-walk datapath: latch the request, capture the next pointer,
    // advance along the chain on each consumed page.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= '0;
            nxt        <= '0;
            remaining  <= '0;
            port       <= '0;
            first_emit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && (req_len != '0)) begin
                        cur       <= req_head;
                        remaining <= req_len;
                        port      <= req_port;
                    end
                end
                LOOKUP: first_emit <= 1'b1;
                EMIT: begin
                    if (first_emit) begin
                        nxt        <= jt_next;
                        first_emit <= 1'b0;
                    end
                    if (page_ready && !is_last) begin
                        cur       <= next_ptr;
                        remaining <= remaining - ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered release stage and zero-length error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_op   <= 1'b0;
            rd_port <= '0;
            rd_addr <= '0;
            len_err <= 1'b0;
        end else begin
            rd_op   <= consume;
            len_err <= accept && (req_len == '0);
            if (consume) begin
                rd_addr <= cur;
                rd_port <= port;
            end
        end
    end

endmodule

// File: tb/tb_page_chain_reader.sv
// Scoreboard bench for page_chain_reader: stimulus pushes expected pages and
// releases, a monitor pops and compares whenever the DUT presents them.
module tb_page_chain_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_port;
    logic [10:0] req_head;
    logic [10:0] req_len;
    logic        page_valid;
    logic        page_ready;
    logic [10:0] page_addr;
    logic        page_last;
    logic        jt_rd_en;
    logic [10:0] jt_rd_addr;
    logic [15:0] jt_dout;
    logic        ecc_rd_en;
    logic [10:0] ecc_rd_addr;
    logic        rd_op;
    logic [3:0]  rd_port;
    logic [10:0] rd_addr;
    logic        len_err;
    logic        busy;

    typedef struct {
        logic [10:0] addr;
        logic        last;
    } page_exp_t;

    typedef struct {
        logic [3:0]  port;
        logic [10:0] addr;
    } rel_exp_t;

    page_exp_t   exp_pages[$];
    rel_exp_t    exp_rel[$];
    logic [15:0] jt_mem[2048];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          jt_cnt   = 0;
    int          rd_cnt   = 0;

    page_chain_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_port   (req_port),
        .req_head   (req_head),
        .req_len    (req_len),
        .page_valid (page_valid),
        .page_ready (page_ready),
        .page_addr  (page_addr),
        .page_last  (page_last),
        .jt_rd_en   (jt_rd_en),
        .jt_rd_addr (jt_rd_addr),
        .jt_dout    (jt_dout),
        .ecc_rd_en  (ecc_rd_en),
        .ecc_rd_addr(ecc_rd_addr),
        .rd_op      (rd_op),
        .rd_port    (rd_port),
        .rd_addr    (rd_addr),
        .len_err    (len_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Jump-table memory model: one-cycle read latency.
    always @(posedge clk) begin
        if (jt_rd_en) jt_dout <= jt_mem[jt_rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compare lookups, accepted pages and releases against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (jt_rd_en) begin
                jt_cnt++;
                check("ecc_rd_en", {31'd0, ecc_rd_en}, 32'd1);
                if (exp_pages.size() == 0) check("lookup_unexpected", 32'd1, 32'd0);
                else begin
                    check("jt_rd_addr", {21'd0, jt_rd_addr}, {21'd0, exp_pages[0].addr});
                    check("ecc_rd_addr", {21'd0, ecc_rd_addr}, {21'd0, exp_pages[0].addr});
                end
            end
            if (page_valid && page_ready) begin
                if (exp_pages.size() == 0) check("page_unexpected", 32'd1, 32'd0);
                else begin
                    page_exp_t e;
                    e = exp_pages.pop_front();
                    check("page_addr", {21'd0, page_addr}, {21'd0, e.addr});
                    check("page_last", {31'd0, page_last}, {31'd0, e.last});
                end
            end
            if (rd_op) begin
                rd_cnt++;
                if (exp_rel.size() == 0) check("rd_op_unexpected", 32'd1, 32'd0);
                else begin
                    rel_exp_t r;
                    r = exp_rel.pop_front();
                    check("rd_addr", {21'd0, rd_addr}, {21'd0, r.addr});
                    check("rd_port", {28'd0, rd_port}, {28'd0, r.port});
                end
            end
        end
    end

    // Issue one request from IDLE and queue the expected chain walk.
    task automatic send_req(input logic [3:0] p, input logic [10:0] h, input logic [10:0] l);
        logic [10:0] a;
        a = h;
        for (int i = 0; i < int'(l); i++) begin
            exp_pages.push_back('{addr: a, last: (i == int'(l) - 1)});
            exp_rel.push_back('{port: p, addr: a});
            a = jt_mem[a][10:0];
        end
        check("req_ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_port  = p;
        req_head  = h;
        req_len   = l;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_pages.size() != 0 || exp_rel.size() != 0) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", {31'd0, (n < 60)}, 32'd1);
    endtask

    task automatic wait_page(input logic [10:0] a);
        int n;
        n = 0;
        while (!page_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_page_valid", {31'd0, page_valid}, 32'd1);
        check("wait_page_addr", {21'd0, page_addr}, {21'd0, a});
    endtask

    task automatic pulse_ready();
        page_ready = 1'b1;
        @(posedge clk);
        #1;
        page_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int jt0, rd0;
        for (int i = 0; i < 2048; i++) jt_mem[i] = 16'h0000;
        // Upper bits set on purpose: they must be ignored.
        jt_mem[10]   = 16'hA000 | 16'd20;
        jt_mem[20]   = 16'h5800 | 16'd7;
        jt_mem[2047] = 16'hF800 | 16'd0;
        jt_mem[30]   = 16'd40;
        jt_mem[40]   = 16'd50;
        jt_mem[50]   = 16'd60;
        jt_dout    = '0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_port   = '0;
        req_head   = '0;
        req_len    = '0;
        page_ready = 1'b1;

        // Reset values.
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_page_valid", {31'd0, page_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd_op", {31'd0, rd_op}, 32'd0);
        check("rst_len_err", {31'd0, len_err}, 32'd0);
        check("rst_jt_rd_en", {31'd0, jt_rd_en}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single page: page at +2 cycles, release one cycle after handshake.
        jt0 = jt_cnt;
        send_req(4'd3, 11'd5, 11'd1);
        check("single_lookup_no_page", {31'd0, page_valid}, 32'd0);
        check("single_lookup_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check("single_page_valid", {31'd0, page_valid}, 32'd1);
        check("single_page_addr", {21'd0, page_addr}, 32'd5);
        check("single_page_last", {31'd0, page_last}, 32'd1);
        @(posedge clk);
        #1;
        check("single_rd_op", {31'd0, rd_op}, 32'd1);
        check("single_rd_addr", {21'd0, rd_addr}, 32'd5);
        check("single_rd_port", {28'd0, rd_port}, 32'd3);
        check("single_busy_drop", {31'd0, busy}, 32'd0);
        wait_idle();
        check("single_jt_once", jt_cnt - jt0, 32'd1);

        // Chain of three, free-running downstream.
        rd0 = rd_cnt;
        send_req(4'd1, 11'd10, 11'd3);
        wait_idle();
        check("chain3_rd_count", rd_cnt - rd0, 32'd3);

        // Same chain with five cycles of backpressure on page 20.
        page_ready = 1'b0;
        send_req(4'd2, 11'd10, 11'd3);
        wait_page(11'd10);
        pulse_ready();
        wait_page(11'd20);
        jt0 = jt_cnt;
        rd0 = rd_cnt;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", {31'd0, page_valid}, 32'd1);
            check("bp_hold_addr", {21'd0, page_addr}, 32'd20);
            check("bp_no_rd_op", {31'd0, rd_op}, 32'd0);
        end
        check("bp_no_relookup", jt_cnt - jt0, 32'd0);
        check("bp_no_release", rd_cnt - rd0, 32'd0);
        page_ready = 1'b1;
        wait_idle();

        // Zero-length request: error pulse only.
        send_req(4'd4, 11'd99, 11'd0);
        check("zero_len_err", {31'd0, len_err}, 32'd1);
        check("zero_req_ready", {31'd0, req_ready}, 32'd1);
        check("zero_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check("zero_len_err_drop", {31'd0, len_err}, 32'd0);
        check("zero_no_page", {31'd0, page_valid}, 32'd0);
        wait_idle();

        // Pointer wrap at the top of the page space.
        send_req(4'd5, 11'd2047, 11'd2);
        wait_idle();

        // Reset while emitting page 2 of 4.
        page_ready = 1'b0;
        send_req(4'd6, 11'd30, 11'd4);
        wait_page(11'd30);
        pulse_ready();
        wait_page(11'd40);
        rst_n = 1'b0;
        #1;
        check("mid_rst_page_valid", {31'd0, page_valid}, 32'd0);
        check("mid_rst_page_addr", {21'd0, page_addr}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_rd_op", {31'd0, rd_op}, 32'd0);
        check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst_rel_done", exp_rel.size(), 32'd3);
        exp_pages.delete();
        exp_rel.delete();
        page_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_req(4'd9, 11'd10, 11'd2);
        wait_idle();

        check("final_pages_drained", exp_pages.size(), 32'd0);
        check("final_rel_drained", exp_rel.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/page_chain_reader.md
Name: page_chain_reader

Overview:
- Read-side stage directly downstream of the SRAM state block.
- Accepts a packet-read request (port, head page, page count) and walks the packet's linked page chain through the jump table.
- Emits each page address to the data-read path, with a matching ECC-storage read.
- When each page is consumed, returns it to the null-page pool through the rd_op/rd_port/rd_addr release interface.

Parameters:
ADDR_WIDTH, 11, page address width (2048 pages)
PORT_WIDTH, 4, port index width (16 ports)
JT_WIDTH, 16, jump-table entry width; bits [ADDR_WIDTH-1:0] hold the next-page pointer, upper bits are ignored

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  packet read request valid
req_ready  output  1  request accepted when req_valid & req_ready
req_port  input  PORT_WIDTH  port the packet belongs to
req_head  input  ADDR_WIDTH  first page address
req_len  input  ADDR_WIDTH  packet length in pages
page_valid  output  1  page address presented downstream
page_ready  input  1  downstream accepts the page
page_addr  output  ADDR_WIDTH  current page address
page_last  output  1  current page is the packet's final page
jt_rd_en  output  1  jump-table read strobe
jt_rd_addr  output  ADDR_WIDTH  jump-table read address
jt_dout  input  JT_WIDTH  jump-table data, valid 1 cycle after jt_rd_en
ecc_rd_en  output  1  ECC read strobe (identical to jt_rd_en)
ecc_rd_addr  output  ADDR_WIDTH  ECC read address (identical to jt_rd_addr)
rd_op  output  1  page-release pulse to the SRAM state block
rd_port  output  PORT_WIDTH  port of the released page
rd_addr  output  ADDR_WIDTH  released page address
len_err  output  1  one-cycle pulse when a zero-length request is accepted
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Clocking and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values: all outputs 0, except req_ready=1. FSM=IDLE. Registers cur, nxt, remaining, port, first_emit cleared.
- FSM states: IDLE, LOOKUP, EMIT.
- IDLE:
  - req_ready=1.
  - On handshake with req_len!=0: cur<=req_head, remaining<=req_len, port<=req_port, go to LOOKUP.
  - On handshake with req_len==0: pulse len_err next cycle, stay in IDLE.
- LOOKUP (1 cycle):
  - jt_rd_en=ecc_rd_en=1 with address cur.
  - req_ready=0.
  - Go to EMIT and set first_emit<=1.
- EMIT:
  - page_valid=1, page_addr=cur, page_last=(remaining==1).
  - Hold all outputs stable while page_ready=0.
  - Next pointer: next = first_emit ? jt_dout[ADDR_WIDTH-1:0] : nxt. In the first EMIT cycle, nxt<=jt_dout[ADDR_WIDTH-1:0] and first_emit<=0; jt_dout is never sampled after that cycle.
  - On page_valid & page_ready:
    - Next cycle: rd_op=1, rd_addr=cur, rd_port=port.
    - If remaining==1: go to IDLE; the next request can be accepted in the cycle after the last handshake.
    - Else: cur<=next, remaining<=remaining-1, go to LOOKUP.
- Throughput: at most one page every 2 cycles. Latency from request handshake to first page_valid is 2 cycles.
- Arithmetic:
  - remaining is ADDR_WIDTH bits and never decrements below 1.
  - The chain pointer is taken verbatim; no bounds check is made, so pointers wrap naturally within 2^ADDR_WIDTH.
- rd_op is a 1-cycle pulse per consumed page. Exactly req_len pulses are produced per packet, in chain order.
- Reset mid-packet: state is discarded immediately. No rd_op is issued for pages not yet consumed; recovery is the owner's responsibility.
- page_ready asserted while page_valid=0 is ignored. req_valid while busy is not accepted.

Decomposition:
- Shared package: ADDR_WIDTH/PORT_WIDTH/JT_WIDTH constants; FSM state enum {IDLE, LOOKUP, EMIT}; jump-table entry field slice (next-pointer LSB/MSB).
- No sub-module: a single FSM with a registered release stage.

Test Plan:
- Single page: req head=5, len=1, port=3, page_ready=1 -> page_addr=5 with page_last=1 at cycle +2; rd_op with rd_addr=5, rd_port=3 one cycle later; busy drops; jt_rd_en exactly once.
- Chain of 3: jump table 10->20, 20->7; req head=10, len=3 -> pages 10, 20, 7 in order; page_last only on 7; three rd_op pulses with addrs 10, 20, 7.
- Backpressure: same chain, hold page_ready=0 for 5 cycles on page 20 -> page_addr stays 20, no rd_op, jt_rd_en not re-asserted; resumes with 7 after release.
- Zero length: req len=0 -> accepted, len_err pulse, no page_valid, no rd_op, req_ready stays 1.
- Wrap pointer: jump table 2047->0; req head=2047, len=2 -> pages 2047 then 0.
- Reset mid-packet: assert rst_n=0 while in EMIT on page 2 of 4 -> outputs zero immediately; after release, req_ready=1, and a new request proceeds normally with no stale rd_op.
